// File: rtl/ahb_sub_mem.sv
// ahb_sub_mem: AHB-Lite subordinate scratch memory.
// Features: an address/data phase pipeline, programmable wait states,
// byte-lane writes derived from size/addr, and the two-cycle ERROR response.
// Optional build macro: AHB_SUB_MEM_STATS_EN adds saturating read/write/error
// counters. Without it, rdCount/wrCount/errCount are tied to zero.
//
// Handshake: an address phase is accepted on a rising edge where
// sel & ready & trans[1] and this block drives readyOut=1. A data phase
// completes on the first edge where readyOut=1 and ready=1. A new accept may
// share that edge (back-to-back). The manager holds the address-phase signals
// while readyOut=0.
module ahb_sub_mem #(
    parameter int DataWidth   = 32,
    parameter int AddrWidth   = 12,
    parameter int Depth       = 256,
    parameter int DefaultWait = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sel,
    input  logic [1:0]           trans,
    input  logic [AddrWidth-1:0] addr,
    input  logic                 write,
    input  logic [2:0]           size,
    input  logic [DataWidth-1:0] wData,
    input  logic                 ready,
    output logic                 readyOut,
    output logic                 resp,
    output logic [DataWidth-1:0] rData,
    input  logic [3:0]           waitCfg,
    input  logic                 errInject,
    output logic [15:0]          rdCount,
    output logic [15:0]          wrCount,
    output logic [15:0]          errCount,
    output logic [1:0]           state_dbg
);

    localparam int ByteW    = DataWidth / 8;
    localparam int LaneBits = $clog2(ByteW);
    localparam int IdxW     = (Depth > 1) ? $clog2(Depth) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } state_t;

    state_t state, next_state;

    // Storage is deliberately not reset: this is a scratch RAM.
    logic [DataWidth-1:0] mem [Depth];

    // Data-phase context captured at accept.
    logic                 dp_active;
    logic                 dp_write;
    logic [AddrWidth-1:0] dp_addr;
    logic [2:0]           dp_size;
    logic [3:0]           wait_cnt;

    logic                 accept;
    logic                 acc_err;
    logic [3:0]           acc_wait;
    logic [31:0]          acc_idx;
    logic [31:0]          dp_idx;
    logic                 complete;
    logic                 commit_wr;
    logic [ByteW-1:0]     wr_be;
    logic [DataWidth-1:0] fwd_word;
    logic                 unused_trans0;

    // Only trans[1] distinguishes a real transfer (NONSEQ/SEQ) from IDLE/BUSY.
    assign unused_trans0 = trans[0];
    assign state_dbg     = state;

    assign dp_idx    = 32'(dp_addr) >> LaneBits;
    assign accept    = sel && ready && trans[1] && readyOut;
    // The completion cycle is IDLE with a live, non-error transfer still pending.
    assign complete  = dp_active && (state == S_IDLE) && ready;
    assign commit_wr = complete && dp_write;

    // Classify the address phase being offered right now.
    always_comb begin
        acc_idx  = 32'(addr) >> LaneBits;
        acc_wait = (waitCfg == 4'd0) ? 4'(DefaultWait) : waitCfg;
        acc_err  = (acc_idx >= 32'(Depth))
                || ({29'd0, size} > 32'(LaneBits))
                || ((32'(addr) & ((32'd1 << size) - 32'd1)) != 32'd0)
                || errInject;
    end

    // Byte lanes touched by the pending write: lane offset .. offset+2^size-1.
    always_comb begin
        int lo;
        int n;
        lo = int'(32'(dp_addr) & 32'(ByteW - 1));
        n  = 1 << dp_size;
        for (int i = 0; i < ByteW; i++) begin
            wr_be[i] = (i >= lo) && (i < lo + n);
        end
    end

    // Zero-wait read data, with the write that is completing this edge folded
    // in, so read-after-write back-to-back returns the new bytes.
    always_comb begin
        fwd_word = mem[acc_idx[IdxW-1:0]];
        if (commit_wr && (dp_idx == acc_idx)) begin
            for (int i = 0; i < ByteW; i++) begin
                if (wr_be[i]) fwd_word[8*i +: 8] = wData[8*i +: 8];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // FSM next state and bus response outputs.
    always_comb begin
        next_state = state;
        readyOut   = 1'b1;
        resp       = 1'b0;
        case (state)
            S_IDLE, S_ERR2: begin
                resp = (state == S_ERR2);
                if (accept) begin
                    if (acc_err)               next_state = S_ERR1;
                    else if (acc_wait != 4'd0) next_state = S_WAIT;
                    else                       next_state = S_IDLE;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_WAIT: begin
                readyOut = 1'b0;
                if (wait_cnt <= 4'd1) next_state = S_IDLE;
            end
            S_ERR1: begin
                readyOut   = 1'b0;
                resp       = 1'b1;
                next_state = S_ERR2;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Data-phase bookkeeping, wait countdown and read data capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_active <= 1'b0;
            dp_write  <= 1'b0;
            dp_addr   <= '0;
            dp_size   <= 3'd0;
            wait_cnt  <= 4'd0;
            rData     <= '0;
        end else begin
            if (accept) begin
                dp_active <= !acc_err;
                dp_write  <= write;
                dp_addr   <= addr;
                dp_size   <= size;
                wait_cnt  <= acc_wait;
                if (!acc_err && !write && (acc_wait == 4'd0)) rData <= fwd_word;
            end else if (complete) begin
                dp_active <= 1'b0;
            end
            if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
                if ((wait_cnt <= 4'd1) && !dp_write) rData <= mem[dp_idx[IdxW-1:0]];
            end
        end
    end

    // Write commit on the completion edge, selected lanes only.
    always_ff @(posedge clk) begin
        if (commit_wr) begin
            for (int i = 0; i < ByteW; i++) begin
                if (wr_be[i]) mem[dp_idx[IdxW-1:0]][8*i +: 8] <= wData[8*i +: 8];
            end
        end
    end

`ifdef AHB_SUB_MEM_STATS_EN
    // Saturating activity counters; errors count on entry to ERR2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdCount  <= 16'd0;
            wrCount  <= 16'd0;
            errCount <= 16'd0;
        end else begin
            if (complete && !dp_write && (rdCount != 16'hFFFF)) rdCount <= rdCount + 16'd1;
            if (commit_wr && (wrCount != 16'hFFFF))             wrCount <= wrCount + 16'd1;
            if ((state == S_ERR1) && (errCount != 16'hFFFF))    errCount <= errCount + 16'd1;
        end
    end
`else
    assign rdCount  = 16'd0;
    assign wrCount  = 16'd0;
    assign errCount = 16'd0;
`endif

endmodule

// File: tb/tb_ahb_sub_mem.sv
// tb_ahb_sub_mem: randomized + directed bench for ahb_sub_mem against a
// transaction-level memory model. Expected read data is queued at accept time.
module tb_ahb_sub_mem;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 256;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          sel;
  logic [1:0]    trans;
  logic [AW-1:0] addr;
  logic          write;
  logic [2:0]    size;
  logic [DW-1:0] wData;
  logic          ready;
  logic          readyOut;
  logic          resp;
  logic [DW-1:0] rData;
  logic [3:0]    waitCfg;
  logic          errInject;
  logic [15:0]   rdCount;
  logic [15:0]   wrCount;
  logic [15:0]   errCount;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  // Single subordinate on the bus: HREADY is our own HREADYOUT.
  assign ready = readyOut;

  ahb_sub_mem #(.DataWidth(DW), .AddrWidth(AW), .Depth(DEPTH), .DefaultWait(0)) dut (
    .clk(clk), .reset(reset), .sel(sel), .trans(trans), .addr(addr), .write(write),
    .size(size), .wData(wData), .ready(ready), .readyOut(readyOut), .resp(resp),
    .rData(rData), .waitCfg(waitCfg), .errInject(errInject), .rdCount(rdCount),
    .wrCount(wrCount), .errCount(errCount), .state_dbg(state_dbg)
  );

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic [31:0]   data;
    logic [3:0]    wcfg;
    bit            inj;
    bit            gap;
    bit            seq;
  } txn_t;

  txn_t        q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  exp_mem [DEPTH*4];
  logic [31:0] last_rd;
  int          m_rd, m_wr, m_err;
  int          n_vec, n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_err(txn_t t);
    int a;
    a = int'(t.addr);
    return ((a >> 2) >= DEPTH) || (t.size > 3'd2) || ((a % (1 << int'(t.size))) != 0) || t.inj;
  endfunction

  function automatic logic [31:0] model_word(int idx);
    return {exp_mem[idx*4+3], exp_mem[idx*4+2], exp_mem[idx*4+1], exp_mem[idx*4]};
  endfunction

  task automatic model_write(txn_t t);
    int a, lane;
    a    = int'(t.addr);
    lane = a % 4;
    for (int k = lane; k < lane + (1 << int'(t.size)); k++) begin
      exp_mem[(a / 4) * 4 + k] = t.data[8*k +: 8];
    end
  endtask

  function automatic txn_t mk(bit wr, int a, int sz, logic [31:0] d, int wc, bit inj, bit gap);
    txn_t t;
    t.wr = wr; t.addr = AW'(a); t.size = 3'(sz); t.data = d;
    t.wcfg = 4'(wc); t.inj = inj; t.gap = gap; t.seq = 1'b0;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int   a, sz;
    t.wr = bit'($urandom_range(0, 1));
    sz   = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
    a    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1024, 4095)) : int'($urandom_range(0, 1023));
    if ($urandom_range(0, 7) != 0) a = a & ~((1 << sz) - 1);
    t.addr = AW'(a);
    t.size = 3'(sz);
    t.data = $urandom();
    t.wcfg = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
    t.inj  = ($urandom_range(0, 15) == 0);
    t.gap  = ($urandom_range(0, 3) == 0);
    t.seq  = bit'($urandom_range(0, 1));
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    sel = 1'b0; trans = 2'd0; addr = '0; write = 1'b0;
    size = 3'd0; waitCfg = 4'd0; errInject = 1'b0;
  endtask

  // Runs the transfer queue as a pipelined manager. Entered and left just
  // after a rising edge. The model decides when the bus is ready; the DUT
  // response is compared against that every cycle.
  task automatic run_queue();
    int          guard;
    int          left;
    bit          ap_valid;
    bit          dp_valid;
    bit          dp_err;
    bit          exp_ro, exp_rs, done;
    int          dp_wait, dp_cyc;
    txn_t        ap, dp;
    logic [31:0] e;
    guard = 0; ap_valid = 0; dp_valid = 0; dp_err = 0; dp_wait = 0; dp_cyc = 0;
    while ((q.size() != 0 || ap_valid || dp_valid) && guard < 20000) begin
      guard++;
      if (!ap_valid && q.size() != 0) begin
        ap = q.pop_front();
        ap_valid = 1;
      end
      wData = dp_valid ? dp.data : $urandom();
      if (ap_valid && !ap.gap) begin
        sel = 1'b1; trans = ap.seq ? 2'd3 : 2'd2; addr = ap.addr; write = ap.wr;
        size = ap.size; waitCfg = ap.wcfg; errInject = ap.inj;
      end else begin
        // No transfer: sel low or IDLE/BUSY, other inputs scrambled.
        sel = 1'($urandom_range(0, 1)); trans = 2'($urandom_range(0, 1));
        addr = AW'($urandom()); write = 1'($urandom_range(0, 1));
        size = 3'($urandom_range(0, 7)); waitCfg = 4'($urandom_range(0, 15));
        errInject = 1'($urandom_range(0, 1));
      end

      @(negedge clk);
      exp_ro = 1; exp_rs = 0; done = 0;
      if (dp_valid) begin
        dp_cyc++;
        if (dp_err) begin
          exp_rs = 1;
          exp_ro = (dp_cyc == 2);
          done   = (dp_cyc == 2);
        end else begin
          exp_ro = (dp_cyc == dp_wait + 1);
          done   = exp_ro;
        end
      end
      check_eq("readyOut", 32'(readyOut), 32'(exp_ro));
      check_eq("resp", 32'(resp), 32'(exp_rs));
      if (done) begin
        if (!dp_err && !dp.wr) begin
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
          check_eq("rData", rData, e);
          last_rd = e;
        end else begin
          check_eq("rData_hold", rData, last_rd);
        end
        dp_valid = 0;
      end
      if (exp_ro && ap_valid) begin
        if (ap.gap) begin
          ap.gap = 0;
        end else begin
          dp = ap; dp_valid = 1; dp_cyc = 0; ap_valid = 0;
          dp_err  = is_err(ap);
          dp_wait = (ap.wcfg == 4'd0) ? 0 : int'(ap.wcfg);
          if (dp_err) m_err++;
          else if (ap.wr) begin model_write(ap); m_wr++; end
          else begin exp_q.push_back(model_word(int'(ap.addr) >> 2)); m_rd++; end
        end
      end
      @(posedge clk); #1;
    end
    drive_idle();
    left = q.size() + int'(ap_valid) + int'(dp_valid);
    check_eq("queue_drained", 32'(left), 32'd0);
    check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_stats();
`ifdef AHB_SUB_MEM_STATS_EN
    check_eq("rdCount", 32'(rdCount), 32'(m_rd));
    check_eq("wrCount", 32'(wrCount), 32'(m_wr));
    check_eq("errCount", 32'(errCount), 32'(m_err));
`else
    check_eq("rdCount", 32'(rdCount), 32'd0);
    check_eq("wrCount", 32'(wrCount), 32'd0);
    check_eq("errCount", 32'(errCount), 32'd0);
`endif
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    n_vec = 0; n_err = 0; m_rd = 0; m_wr = 0; m_err = 0; last_rd = 32'd0;
    reset = 1'b1;
    drive_idle();
    wData = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_readyOut", 32'(readyOut), 32'd1);
    check_eq("rst_resp", 32'(resp), 32'd0);
    check_eq("rst_rData", rData, 32'd0);
    check_eq("rst_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Preload every word so reads never see uninitialised storage.
    for (int i = 0; i < DEPTH; i++) q.push_back(mk(1, i * 4, 2, $urandom(), 0, 0, 0));
    run_queue();

    // Directed cases.
    q.push_back(mk(1, 'h010, 2, 32'hDEADBEEF, 0, 0, 0));
    q.push_back(mk(0, 'h010, 2, 32'h0, 0, 0, 0));          // RAW back-to-back
    q.push_back(mk(0, 'h020, 2, 32'h0, 3, 0, 1));          // 3 wait states
    q.push_back(mk(0, 'h024, 2, 32'h0, 3, 0, 0));
    q.push_back(mk(1, 'h030, 2, 32'h11223344, 0, 0, 1));
    q.push_back(mk(1, 'h032, 0, 32'h5CAA7E91, 0, 0, 0));   // byte lane 2 = AA
    q.push_back(mk(0, 'h030, 2, 32'h0, 0, 0, 0));          // 11AA3344
    q.push_back(mk(1, 'h031, 1, 32'hFFFFFFFF, 0, 0, 0));   // misaligned -> ERROR
    q.push_back(mk(0, 'h030, 2, 32'h0, 0, 0, 0));          // unchanged
    q.push_back(mk(0, DEPTH * 4, 2, 32'h0, 0, 0, 0));      // out of range
    q.push_back(mk(0, 'h030, 2, 32'h0, 1, 1, 0));          // injected error
    q.push_back(mk(0, 'h030, 2, 32'h0, 0, 0, 0));
    q.push_back(mk(0, 'h038, 3, 32'h0, 0, 0, 0));          // size too big
    q.push_back(mk(1, 'h036, 1, 32'h9876ABCD, 2, 0, 0));   // upper halfword
    q.push_back(mk(0, 'h034, 2, 32'h0, 0, 0, 0));
    run_queue();
    check_eq("byte_lane_word", model_word('h030 >> 2), 32'h11AA3344);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) q.push_back(rand_txn());
    run_queue();
    check_stats();

    // Reset while a 4-wait write still has 2 wait states to go.
    sel = 1'b1; trans = 2'd2; addr = AW'('h040); write = 1'b1; size = 3'd2;
    waitCfg = 4'd4; errInject = 1'b0;
    @(posedge clk); #1;
    drive_idle();
    wData = 32'hCAFEF00D;
    check_eq("wait_w1_readyOut", 32'(readyOut), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("wait_w3_readyOut", 32'(readyOut), 32'd0);
    reset = 1'b1;
    #1;
    check_eq("async_readyOut", 32'(readyOut), 32'd1);
    check_eq("async_resp", 32'(resp), 32'd0);
    check_eq("async_rData", rData, 32'd0);
    check_eq("async_state", 32'(state_dbg), 32'd0);
    m_rd = 0; m_wr = 0; m_err = 0; last_rd = 32'd0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_stats();

    // Post-reset: 3 reads, 2 writes, 1 error; 0x040 must hold its old value.
    q.push_back(mk(0, 'h040, 2, 32'h0, 0, 0, 0));
    q.push_back(mk(1, 'h050, 2, 32'hA5A55A5A, 1, 0, 0));
    q.push_back(mk(0, 'h050, 2, 32'h0, 0, 0, 0));
    q.push_back(mk(1, 'h054, 0, 32'h000000C3, 0, 0, 1));
    q.push_back(mk(0, 'h044, 2, 32'h0, 2, 1, 0));
    q.push_back(mk(0, 'h054, 2, 32'h0, 2, 0, 0));
    run_queue();
    repeat (3) @(posedge clk);
    #1;
    check_stats();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_sub_mem.md
Name: ahb_sub_mem

Overview:
Parametrised AHB-Lite subordinate memory. It is the next-generation test and target device for the AHB fabric.
- Implements a proper address/data phase pipeline, programmable wait states, byte-lane writes from size/addr, and the two-cycle ERROR response.
- Errors are triggered by range, alignment, size or injection.
- Sits behind the decoder/mux alongside other subordinates; used by manager benches and as a scratch RAM.

Parameters:
DataWidth, 32, data bus width in bits (power of 2, 8..64)
AddrWidth, 12, byte address width
Depth, 256, memory depth in DataWidth words; word index = addr >> log2(DataWidth/8)
DefaultWait, 0, wait states per transfer applied while waitCfg == 0

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
sel  in  1  subordinate select from decoder
trans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
addr  in  AddrWidth  byte address (address phase)
write  in  1  1=write, 0=read (address phase)
size  in  3  transfer size, 2^size bytes
wData  in  DataWidth  write data (data phase)
ready  in  1  bus HREADY (mux output)
readyOut  out  1  subordinate HREADYOUT
resp  out  1  0=OKAY, 1=ERROR
rData  out  DataWidth  read data
waitCfg  in  4  runtime wait states; 0 selects DefaultWait
errInject  in  1  force ERROR on the next accepted transfer

Behaviour:
- Reset (async, any state, including mid-transfer): readyOut=1, resp=OKAY, rData=0, FSM=IDLE, pending transfer dropped. Memory contents are not reset.
- Address-phase accept: on posedge when sel & ready & trans[1] (NONSEQ/SEQ). Latch addr, write, size and errInject, and load waitCnt from the effective wait.
- IDLE/BUSY, or sel=0, with ready=1: no transfer. Next cycle readyOut=1, resp=OKAY.
- Error check at accept. The transfer is an error if any of the following holds:
  - word index >= Depth;
  - size > log2(DataWidth/8);
  - addr not aligned to 2^size;
  - errInject sampled 1.
- FSM states: IDLE, WAIT, ERR1, ERR2.
- IDLE:
  - On an accept with error: go to ERR1.
  - On an accept with wait > 0: go to WAIT.
  - On an accept with wait = 0: stay IDLE. The data phase completes in the next cycle with readyOut=1, resp=OKAY, zero-wait.
- WAIT: readyOut=0, resp=OKAY; waitCnt decrements each cycle. When waitCnt reaches 1, the next cycle is the completion cycle (readyOut=1, resp=OKAY). Total data phase is N+1 cycles for N wait states.
- ERR1: readyOut=0, resp=ERROR for exactly one cycle, then ERR2.
- ERR2: readyOut=1, resp=ERROR for one cycle.
  - A new transfer accepted at the end of ERR2 is processed normally.
  - A manager driving IDLE instead is legal.
- Error transfers never modify memory. rData is held.
- Read completion: rData = mem[index] during the cycle readyOut=1. The read is performed on entry to the completion cycle.
- Write completion: wData is sampled on the completion cycle edge (readyOut=1 and ready=1).
  - Only byte lanes addr[log2(DataWidth/8)-1:0] .. +2^size-1 are written.
  - Other lanes are unchanged.
- Pipelining: an accept may coincide with a completion edge (back-to-back). Zero-wait back-to-back transfers sustain 1 transfer/cycle.
- Read-after-write to the same address back-to-back returns the new data: the write commits before the read's completion cycle.
- waitCfg and errInject are sampled only at accept. Changes during the data phase have no effect on the in-flight transfer.
- sel deasserted during a data phase does not abort the transfer; it completes normally.

Optional Feature:
Macro AHB_SUB_MEM_STATS_EN.
- Defined: adds outputs rdCount, wrCount and errCount (16 bits each, reset 0, saturating at 0xFFFF).
  - rdCount/wrCount increment on each OKAY read/write completion.
  - errCount increments on entry to ERR2.
- Undefined: the ports still exist and are tied to 0; no counter logic.

Test Plan:
- Write 0xDEADBEEF @0x010 size=2 wait=0, then read @0x010 back-to-back -> read completes 1 cycle after its address phase with rData=0xDEADBEEF, resp=OKAY, no readyOut low.
- waitCfg=3, read @0x020 -> readyOut low for exactly 3 cycles, then high with valid rData; throughput 1 transfer per 4 cycles.
- Preload @0x030=0x11223344; byte write 0xAA at addr 0x032 size=0 -> read returns 0x11AA3344; halfword at 0x031 -> ERR1/ERR2 sequence, memory unchanged.
- Access word index Depth (addr=Depth*4), and separately errInject=1 on a valid address -> resp=ERROR with readyOut 0 then 1, next NONSEQ transfer completes OKAY.
- Assert reset in WAIT with 2 wait states remaining -> readyOut=1, resp=OKAY immediately (async), no write committed, next transfer behaves normally.
- With AHB_SUB_MEM_STATS_EN: 3 reads, 2 writes, 1 error -> rdCount=3, wrCount=2, errCount=1; without the macro all counts read 0.
